// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite frame loader: engine register map,
// write-bus encodings, record length and the sequencer state type.
package sprite_pkg;

  // Engine register map
  localparam logic [5:0] CTRL_ADDR = 6'h00;
  localparam logic [5:0] SPR0_BASE = 6'h04;
  localparam logic [5:0] SPR1_BASE = 6'h1A;

  // Halfwords per sprite record: position word plus nine bitmap words
  localparam logic [3:0] REC_WORDS = 4'd10;

  // Engine write-strobe encodings (active-low pair)
  localparam logic [1:0] BUS_IDLE = 2'b11;
  localparam logic [1:0] BUS_W8   = 2'b00;
  localparam logic [1:0] BUS_W16  = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ARMED = 3'd2,
    ST_DIS   = 3'd3,
    ST_BURST = 3'd4,
    ST_EN    = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  // Register address of halfword idx within the selected sprite's block
  function automatic logic [5:0] burst_addr(input logic sel, input logic [3:0] idx);
    logic [5:0] base_s;
    base_s = sel ? SPR1_BASE : SPR0_BASE;
    return base_s + {1'b0, idx, 1'b0};
  endfunction

endpackage

// File: rtl/sprite_rec_buf.sv
// Record buffer: REC_WORDS x 16-bit register file, one write port and one
// combinational read port. Out-of-range indices write nothing and read zero.
module sprite_rec_buf
  import sprite_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [3:0]  wr_idx,
  input  logic [15:0] wr_data,
  input  logic [3:0]  rd_idx,
  output logic [15:0] rd_data
);

  logic [15:0] mem_r [0:REC_WORDS-4'd1];

  // Store one halfword per accepted host beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(REC_WORDS); i++) begin
        mem_r[i] <= 16'h0000;
      end
    end else if (wr_en && (wr_idx < REC_WORDS)) begin
      mem_r[wr_idx] <= wr_data;
    end
  end

  // Combinational read of the halfword selected by the sequencer
  always_comb begin
    rd_data = 16'h0000;
    if (rd_idx < REC_WORDS) begin
      rd_data = mem_r[rd_idx];
    end else begin
      rd_data = 16'h0000;
    end
  end

endmodule

// File: rtl/sprite_frame_loader.sv
// Sprite frame loader: buffers one host sprite record and, on the next vsync
// rising edge, writes it to the sprite engine as an atomic burst framed by a
// stream-disable and a stream-restore of the engine control register.
// Optional macro SPRITE_LOADER_TIMEOUT_EN: bounds the vsync wait and adds the
// timed_out pulse output.
module sprite_frame_loader
  import sprite_pkg::*;
`ifdef SPRITE_LOADER_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd1100000
)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rec_valid,
  output logic        rec_ready,
  input  logic [15:0] rec_data,
  input  logic        rec_sel,
  input  logic        rec_last,
  input  logic [2:0]  ctrl_val,
  input  logic        vsync,
  output logic [5:0]  bus_addr,
  output logic [31:0] bus_data,
  output logic [1:0]  bus_write_n,
  output logic        busy,
  output logic        done,
`ifdef SPRITE_LOADER_TIMEOUT_EN
  output logic        timed_out,
`endif
  output logic        err
);

  state_e      state_r, next_state_s;
  logic [3:0]  count_r, count_next_s;
  logic [3:0]  idx_r, idx_next_s;
  logic        sel_r, sel_next_s;
  logic        err_r, err_next_s;
  logic [2:0]  ctrl_q_r, ctrl_next_s;
  logic        vsync_d_r;
  logic        vs_edge_s;
  logic        accept_s;
  logic        rec_ready_r;
  logic        busy_r, done_r;
  logic [5:0]  bus_addr_r, addr_next_s;
  logic [31:0] bus_data_r, data_next_s;
  logic [1:0]  bus_wn_r, wn_next_s;
  logic        wr_en_s;
  logic [3:0]  wr_idx_s, rd_idx_s;
  logic [15:0] rd_data_s;

`ifdef SPRITE_LOADER_TIMEOUT_EN
  localparam logic [20:0] TMO_LAST = 21'(TIMEOUT_CYCLES - 32'd1);
  logic [20:0] tmo_cnt_r, tmo_cnt_next_s;
  logic        tmo_hit_r, tmo_hit_next_s;
  logic        timed_out_r;
`endif

  sprite_rec_buf u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en_s),
    .wr_idx  (wr_idx_s),
    .wr_data (rec_data),
    .rd_idx  (rd_idx_s),
    .rd_data (rd_data_s)
  );

  assign vs_edge_s = vsync & ~vsync_d_r;
  assign accept_s  = rec_valid & rec_ready_r;

  // Next-state, record bookkeeping and next bus cycle selection
  always_comb begin
    next_state_s = state_r;
    count_next_s = count_r;
    idx_next_s   = idx_r;
    sel_next_s   = sel_r;
    err_next_s   = err_r;
    ctrl_next_s  = ctrl_q_r;
    wr_en_s      = 1'b0;
    wr_idx_s     = count_r;
    rd_idx_s     = idx_r;
    addr_next_s  = CTRL_ADDR;
    data_next_s  = 32'h0000_0000;
    wn_next_s    = BUS_IDLE;
`ifdef SPRITE_LOADER_TIMEOUT_EN
    tmo_cnt_next_s = (state_r == ST_ARMED) ? (tmo_cnt_r + 21'd1) : 21'd0;
    tmo_hit_next_s = tmo_hit_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (rec_last) begin
            // A one-word record is a length error; stay idle
            err_next_s = 1'b1;
          end else begin
            wr_en_s      = 1'b1;
            wr_idx_s     = 4'd0;
            sel_next_s   = rec_sel;
            count_next_s = 4'd1;
            err_next_s   = 1'b0;
            next_state_s = ST_FILL;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (accept_s) begin
          if (rec_last) begin
            if ((count_r + 4'd1) == REC_WORDS) begin
              wr_en_s      = 1'b1;
              count_next_s = count_r + 4'd1;
              next_state_s = ST_ARMED;
            end else begin
              err_next_s   = 1'b1;
              count_next_s = 4'd0;
              next_state_s = ST_IDLE;
            end
          end else if (count_r == REC_WORDS) begin
            // Word beyond the record length without a terminator
            err_next_s   = 1'b1;
            count_next_s = 4'd0;
            next_state_s = ST_IDLE;
          end else begin
            wr_en_s      = 1'b1;
            count_next_s = count_r + 4'd1;
          end
        end else begin
          next_state_s = ST_FILL;
        end
      end
      ST_ARMED: begin
        if (vs_edge_s) begin
          ctrl_next_s  = ctrl_val;
          wn_next_s    = BUS_W8;
          data_next_s  = {29'h0000_0000, ctrl_val & 3'b110};
          next_state_s = ST_DIS;
        end
`ifdef SPRITE_LOADER_TIMEOUT_EN
        else if (tmo_cnt_r == TMO_LAST) begin
          ctrl_next_s    = ctrl_val;
          wn_next_s      = BUS_W8;
          data_next_s    = {29'h0000_0000, ctrl_val & 3'b110};
          tmo_hit_next_s = 1'b1;
          next_state_s   = ST_DIS;
        end
`endif
        else begin
          next_state_s = ST_ARMED;
        end
      end
      ST_DIS: begin
        rd_idx_s     = 4'd0;
        addr_next_s  = burst_addr(sel_r, 4'd0);
        wn_next_s    = BUS_W16;
        data_next_s  = {16'h0000, rd_data_s};
        idx_next_s   = 4'd1;
        next_state_s = ST_BURST;
      end
      ST_BURST: begin
        if (idx_r == REC_WORDS) begin
          // All halfwords issued: restore the original control value
          wn_next_s    = BUS_W8;
          data_next_s  = {29'h0000_0000, ctrl_q_r};
          idx_next_s   = 4'd0;
          next_state_s = ST_EN;
        end else begin
          rd_idx_s     = idx_r;
          addr_next_s  = burst_addr(sel_r, idx_r);
          wn_next_s    = BUS_W16;
          data_next_s  = {16'h0000, rd_data_s};
          idx_next_s   = idx_r + 4'd1;
          next_state_s = ST_BURST;
        end
      end
      ST_EN: begin
        next_state_s = ST_DONE;
      end
      ST_DONE: begin
        count_next_s = 4'd0;
`ifdef SPRITE_LOADER_TIMEOUT_EN
        tmo_hit_next_s = 1'b0;
`endif
        next_state_s = ST_IDLE;
      end
      default: begin
        count_next_s = 4'd0;
        idx_next_s   = 4'd0;
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      count_r     <= 4'd0;
      idx_r       <= 4'd0;
      sel_r       <= 1'b0;
      err_r       <= 1'b0;
      ctrl_q_r    <= 3'b000;
      vsync_d_r   <= 1'b0;
      rec_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      bus_addr_r  <= 6'h00;
      bus_data_r  <= 32'h0000_0000;
      bus_wn_r    <= BUS_IDLE;
`ifdef SPRITE_LOADER_TIMEOUT_EN
      tmo_cnt_r   <= 21'd0;
      tmo_hit_r   <= 1'b0;
      timed_out_r <= 1'b0;
`endif
    end else begin
      state_r     <= next_state_s;
      count_r     <= count_next_s;
      idx_r       <= idx_next_s;
      sel_r       <= sel_next_s;
      err_r       <= err_next_s;
      ctrl_q_r    <= ctrl_next_s;
      vsync_d_r   <= vsync;
      rec_ready_r <= (next_state_s == ST_IDLE) || (next_state_s == ST_FILL);
      busy_r      <= (next_state_s != ST_IDLE);
      done_r      <= (next_state_s == ST_DONE);
      bus_addr_r  <= addr_next_s;
      bus_data_r  <= data_next_s;
      bus_wn_r    <= wn_next_s;
`ifdef SPRITE_LOADER_TIMEOUT_EN
      tmo_cnt_r   <= tmo_cnt_next_s;
      tmo_hit_r   <= tmo_hit_next_s;
      timed_out_r <= tmo_hit_r && (next_state_s == ST_DONE);
`endif
    end
  end

  assign rec_ready   = rec_ready_r;
  assign bus_addr    = bus_addr_r;
  assign bus_data    = bus_data_r;
  assign bus_write_n = bus_wn_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err         = err_r;
`ifdef SPRITE_LOADER_TIMEOUT_EN
  assign timed_out   = timed_out_r;
`endif

endmodule

// File: doc/sprite_frame_loader.md
Name: sprite_frame_loader

Overview:
- Upstream feeder for the 2-sprite engine peripheral.
- Accepts one sprite record from a host stream: 10 halfwords, position first, then bitmap words 0..8. Buffers the record internally and waits for a frame boundary (vsync rising edge).
- At that boundary it drives the engine's register-write bus in an atomic burst: stream-disable, 10 halfword writes, stream-restore.
- Sprite updates therefore land in the interval between frames, with no tearing.

Parameters:
- CTRL_ADDR, 6'h00, engine control register address.
- SPR0_BASE, 6'h04, sprite 0 position address; bitmap words follow at +2 steps.
- SPR1_BASE, 6'h1A, sprite 1 position address.
- REC_WORDS, 10, halfwords per record.
- TIMEOUT_CYCLES, 1100000, vsync wait limit (one 1344x806 frame plus margin); used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low
- rec_valid  in  1  host word valid
- rec_ready  out  1  loader accepts word
- rec_data  in  16  halfword; word0 = {y[15:8], x[7:0]}
- rec_sel  in  1  target sprite; sampled with word0 only
- rec_last  in  1  marks final word of a record
- ctrl_val  in  3  engine control value to restore; sampled on vsync edge
- vsync  in  1  engine vsync output (uo_out[7])
- bus_addr  out  6  engine address
- bus_data  out  32  engine write data; upper 16 bits are 0
- bus_write_n  out  2  11 = idle, 00 = 8-bit, 01 = 16-bit
- busy  out  1  high outside IDLE
- done  out  1  1-cycle pulse when the burst completes
- err  out  1  sticky record-length error; cleared by the next accepted word0

Behaviour:
- Reset values: rec_ready=0, bus_write_n=11, bus_addr=0, bus_data=0, busy=0, done=0, err=0, word count 0, state IDLE.
- States: IDLE, FILL, ARMED, DIS, BURST, EN, DONE.
- IDLE:
  - rec_ready=1.
  - On a word0 handshake: store word, latch rec_sel, count=1, clear err, go to FILL.
- FILL:
  - rec_ready=1.
  - Each handshake stores buf[count] and increments count.
  - rec_last with count+1==REC_WORDS: go to ARMED.
  - rec_last with any other count, or an 11th word without rec_last: discard record, err=1, go to IDLE.
  - rec_last on word0 in IDLE is also a length error and stays IDLE.
- ARMED:
  - rec_ready=0.
  - vsync edge = vsync & ~vsync_d (registered previous value).
  - On the edge: latch ctrl_val, go to DIS.
  - If vsync is already high on entry, no edge is seen; the next rising edge is required.
- DIS (1 cycle): addr=CTRL_ADDR, bus_write_n=00, data={29'b0, ctrl_q & 3'b110}.
- BURST (REC_WORDS cycles, one write per cycle):
  - addr = base + 2*i, where base is SPR0_BASE or SPR1_BASE from the latched sel.
  - bus_write_n=01, data={16'b0, buf[i]}, i = 0..9.
  - The first BURST write follows DIS by exactly 1 cycle; the engine's enable bit is clear by then.
  - Address arithmetic is 6-bit; with the defaults it never wraps (max 0x2C).
- EN (1 cycle): addr=CTRL_ADDR, bus_write_n=00, data={29'b0, ctrl_q}.
- DONE (1 cycle): done=1, bus idle, then go to IDLE.
- Bus outputs are registered.
  - Latency from vsync edge to first bus write (DIS) is 1 cycle.
  - Total burst length is REC_WORDS+2 write cycles.
- busy=1 in every state except IDLE.
- The engine data_ready is always 1, so there are no bus wait states.
- Reset mid-burst:
  - Outputs return to reset values immediately at the reset edge.
  - The engine may be left with streaming disabled; firmware must rewrite control afterwards. This is accepted behaviour.
- ctrl_val changes after the vsync edge do not affect the current burst.

Optional Feature:
- Macro: SPRITE_LOADER_TIMEOUT_EN.
- Defined:
  - A 21-bit counter runs in ARMED.
  - If it reaches TIMEOUT_CYCLES with no vsync edge (engine stream stopped): latch ctrl_val, proceed to DIS, and assert extra output port timed_out as a 1-cycle pulse alongside done.
- Undefined:
  - ARMED waits indefinitely.
  - No counter and no timed_out port.

Decomposition:
- Shared package sprite_pkg holds:
  - address constants CTRL_ADDR, SPR0_BASE, SPR1_BASE;
  - bus encodings BUS_IDLE=2'b11, BUS_W8=2'b00, BUS_W16=2'b01;
  - REC_WORDS;
  - the state enum.
- One sub-module: sprite_rec_buf, a 10x16 register file with a write-index port and a read-index port.
- Sequencing stays in the top-level module.

Test Plan:
- Sprite 0 record (pos 16'h0A05, bmp words 16'h1000..16'h1008), then one vsync rise:
  - exactly 12 writes in consecutive cycles:
    - addr 00 data 0 (w8, with ctrl_val=3'b001);
    - addrs 04,06,…,16 with matching data (w16);
    - addr 00 data 1 (w8);
  - then done pulse; busy low the cycle after done.
- rec_sel=1 record: addresses 1A,1C,…,2C; no write to 04–16.
- 9-word record with rec_last on word 9: err=1, no bus activity on the following vsync, back in IDLE with rec_ready=1.
- Record completed while vsync already high: no writes until vsync falls and rises again.
- ctrl_val=3'b111 at the edge, changed to 3'b000 during BURST: DIS data=6, EN data=7.
- Reset asserted at the 5th BURST cycle: next cycle bus_write_n=11, busy=0. With SPRITE_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=100, and vsync held low: DIS 100 cycles after ARMED, timed_out pulses with done.
